// File: rtl/ofmap_glb_writer_if.sv
`timescale 1ns/1ps
// ofmap_glb_writer_if
// Global-buffer write port: one row-wide word per handshake.
// The writer drives wren/addr/wdata; the GLB answers with ready.
interface ofmap_glb_writer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_W     = 112
);
    logic                  wren;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic                  ready;

    modport master (
        output wren,
        output addr,
        output wdata,
        input  ready
    );

    modport slave (
        input  wren,
        input  addr,
        input  wdata,
        output ready
    );
endinterface

// File: rtl/ofmap_glb_writer.sv
`timescale 1ns/1ps
// ofmap_glb_writer
// Takes column-skewed ofmap rows from the accumulators, deskews them into aligned
// PE_SIZE-lane words, buffers them in a small show-ahead FIFO and writes them to the
// GLB at sequential addresses starting from a latched base. A tile is ROW_NUM rows;
// done_o pulses once the last row has been accepted by the GLB.
module ofmap_glb_writer #(
    parameter int PE_SIZE    = 14,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int ROW_NUM    = 70,
    parameter int BUF_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_i,
    input  logic                          ofmap_valid_i,
    ofmap_glb_writer_if.master            glb,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o
);

    localparam int ROW_W = DATA_WIDTH * PE_SIZE;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(ROW_NUM + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic                  busy_q;
    logic                  done_q;
    logic                  overflow_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      push_cnt;
    logic [CNT_W-1:0]      wr_cnt;

    // deskew
    logic [PE_SIZE-2:0]    vld_q;
    logic [ROW_W-1:0]      aligned_row;
    logic                  strobe_in;

    // FIFO
    logic [ROW_W-1:0]      mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        fill;
    logic                  fifo_full;
    logic                  fifo_empty;

    // control
    logic                  in_run;
    logic                  wren_int;
    logic                  pop;
    logic                  push_req;
    logic                  do_push;
    logic                  last_write;

    assign in_run     = (state == RUN);
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == (PTR_W+1)'(BUF_DEPTH));
    assign wren_int   = in_run && !fifo_empty;
    assign pop        = wren_int && glb.ready;
    assign last_write = (wr_cnt == CNT_W'(ROW_NUM - 1));

    // Strobes only count while a tile is running; the pipe itself decides push timing.
    assign strobe_in  = ofmap_valid_i && in_run;

    // A row emerging from the pipe is a push attempt only if the tile still wants rows.
    // A full FIFO can still take it when the head leaves in the same cycle.
    assign push_req   = vld_q[PE_SIZE-2] && (push_cnt < CNT_W'(ROW_NUM));
    assign do_push    = push_req && (!fifo_full || pop) && !start_i;

    // Lane 0 arrives last, so it needs no delay; lane j arrives j cycles earlier.
    assign aligned_row[DATA_WIDTH-1:0] = ofmap_row_i[DATA_WIDTH-1:0];

    for (genvar j = 1; j < PE_SIZE; j++) begin : g_lane
        logic [DATA_WIDTH-1:0] dly_q [j];

        // Delay lane j by j cycles so it lines up with lane 0 of the same row.
        always_ff @(posedge clk) begin
            dly_q[0] <= ofmap_row_i[DATA_WIDTH*j +: DATA_WIDTH];
            for (int k = 1; k < j; k++) begin
                dly_q[k] <= dly_q[k-1];
            end
        end

        assign aligned_row[DATA_WIDTH*j +: DATA_WIDTH] = dly_q[j-1];
    end

    // Carry each row strobe along PE_SIZE-1 stages so it meets the fully aligned row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (start_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= strobe_in;
            for (int k = 1; k < PE_SIZE - 1; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // FIFO storage; the head is read combinationally so it can drive wdata directly.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= aligned_row;
        end
    end

    // FIFO pointers and occupancy; a restart empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (start_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, pop})
                2'b10:   fill <= fill + (PTR_W+1)'(1);
                2'b01:   fill <= fill - (PTR_W+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Tile bookkeeping: base latch, push/write counts and the sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            push_cnt   <= '0;
            wr_cnt     <= '0;
            overflow_q <= 1'b0;
        end else if (start_i) begin
            base_q     <= base_addr_i;
            push_cnt   <= '0;
            wr_cnt     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_req) begin
                push_cnt <= push_cnt + CNT_W'(1);
            end
            if (pop) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
            if (push_req && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Tile sequencer with registered busy/done; a start always (re)enters RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!start_i && pop && last_write) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state <= RUN;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Address and data are forced to zero when no write is requested, so the bus is
    // quiet after reset and between tiles.
    assign glb.wren   = wren_int;
    assign glb.addr   = wren_int ? (base_q + ADDR_WIDTH'(wr_cnt)) : '0;
    assign glb.wdata  = wren_int ? mem[rd_ptr] : '0;

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ofmap_glb_writer.sv
`timescale 1ns/1ps
// tb_ofmap_glb_writer
// Drives skewed ofmap rows into ofmap_glb_writer (PE_SIZE=4, ROW_NUM=6, BUF_DEPTH=4)
// and compares every cycle against a queue-based model of the tile/FIFO rules,
// plus directed scenarios with hand-computed expectations.
module tb_ofmap_glb_writer;

    localparam int PE = 4;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int RN = 6;
    localparam int BD = 4;
    localparam int RW = PE * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [RW-1:0] ofmap_row_i = '0;
    logic          ofmap_valid_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;

    ofmap_glb_writer_if #(.ADDR_WIDTH(AW), .DATA_W(RW)) glb_bus ();

    ofmap_glb_writer #(
        .PE_SIZE   (PE),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ROW_NUM   (RN),
        .BUF_DEPTH (BD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .ofmap_row_i  (ofmap_row_i),
        .ofmap_valid_i(ofmap_valid_i),
        .glb          (glb_bus),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check_output(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // free-running cycle index shared by driver, lane builder and model
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // row data by strobe cycle
    logic [RW-1:0] row_at [int];

    // lane j carries the row strobed PE-1-j cycles ago; otherwise junk
    logic [RW-1:0] lanes;
    int            src_cyc;
    always @(posedge clk) begin
        #2;
        for (int j = 0; j < PE; j++) begin
            src_cyc = cyc - (PE - 1 - j);
            if (row_at.exists(src_cyc)) lanes[j*DW +: DW] = row_at[src_cyc][j*DW +: DW];
            else                        lanes[j*DW +: DW] = DW'($urandom);
        end
        ofmap_row_i = lanes;
    end

    // write log used by the directed checks
    logic [AW-1:0] log_addr [$];
    logic [RW-1:0] log_data [$];
    int            log_cyc  [$];
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (glb_bus.wren && glb_bus.ready) begin
                log_addr.push_back(glb_bus.addr);
                log_data.push_back(glb_bus.wdata);
                log_cyc.push_back(cyc);
            end
            if (done_o) done_cnt++;
        end
    end

    // reference model: tile flag, done pulse, queue FIFO and pending rows by due cycle
    bit            m_running;
    bit            m_done;
    bit            m_ovf;
    int            m_push_cnt;
    int            m_wr_cnt;
    logic [AW-1:0] m_base;
    logic [RW-1:0] m_fifo [$];
    int            pend_due [$];
    logic [RW-1:0] pend_data [$];
    bit            exp_wren;
    bit            do_pop;
    bit            last_wr;
    int            occ_before;
    logic [RW-1:0] pdata;
    logic [AW-1:0] exp_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_running = 0; m_done = 0; m_ovf = 0;
            m_push_cnt = 0; m_wr_cnt = 0; m_base = '0;
            m_fifo.delete(); pend_due.delete(); pend_data.delete();
            check_output("reset_wren", glb_bus.wren, 0);
            check_output("reset_busy", busy_o, 0);
            check_output("reset_done", done_o, 0);
            check_output("reset_overflow", overflow_o, 0);
        end else begin
            exp_wren = m_running && (m_fifo.size() > 0);
            check_output("wren", glb_bus.wren, exp_wren);
            check_output("busy", busy_o, m_running || m_done);
            check_output("done", done_o, m_done);
            check_output("overflow", overflow_o, m_ovf);
            if (exp_wren) begin
                exp_addr = m_base + AW'(m_wr_cnt);
                check_output("addr", glb_bus.addr, exp_addr);
                check_output("wdata", glb_bus.wdata, m_fifo[0]);
            end
            do_pop = exp_wren && glb_bus.ready;
            if (start_i) begin
                m_running = 1; m_done = 0; m_ovf = 0;
                m_push_cnt = 0; m_wr_cnt = 0; m_base = base_addr_i;
                m_fifo.delete(); pend_due.delete(); pend_data.delete();
            end else begin
                occ_before = m_fifo.size();
                last_wr = do_pop && (m_wr_cnt == RN - 1);
                if (do_pop) begin
                    void'(m_fifo.pop_front());
                    m_wr_cnt++;
                end
                if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                    pdata = pend_data.pop_front();
                    void'(pend_due.pop_front());
                    if (m_push_cnt < RN) begin
                        m_push_cnt++;
                        if (occ_before == BD && !do_pop) m_ovf = 1;
                        else                             m_fifo.push_back(pdata);
                    end
                end
                if (m_running && ofmap_valid_i && row_at.exists(cyc)) begin
                    pend_due.push_back(cyc + PE - 1);
                    pend_data.push_back(row_at[cyc]);
                end
                m_done = 0;
                if (last_wr) begin
                    m_running = 0;
                    m_done = 1;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic start, input logic [AW-1:0] base,
                                  input logic valid, input logic [RW-1:0] row,
                                  input logic ready);
        @(posedge clk);
        #1;
        start_i       = start;
        base_addr_i   = base;
        ofmap_valid_i = valid;
        glb_bus.ready = ready;
        if (valid) row_at[cyc] = row;
    endtask

    task automatic idle(input int n, input logic ready);
        repeat (n) apply_stimulus(1'b0, base_addr_i, 1'b0, '0, ready);
    endtask

    function automatic logic [RW-1:0] row_pat(input int r);
        return {8'(16*r + 3), 8'(16*r + 2), 8'(16*r + 1), 8'(16*r)};
    endfunction

    function automatic logic [63:0] addr_at(input int i);
        if (i < log_addr.size()) return 64'(log_addr[i]);
        return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] data_at(input int i);
        if (i < log_data.size()) return 64'(log_data[i]);
        return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic void clear_logs();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endfunction

    initial begin
        int   strobe_cyc;
        int   done_base;
        int   n_before;
        bit   ok;
        logic v, rdy, st;

        glb_bus.ready = 1'b0;
        rst_n = 1'b0;
        idle(3, 1'b0);
        check_output("t0_busy", busy_o, 0);
        check_output("t0_wren", glb_bus.wren, 0);
        check_output("t0_addr", glb_bus.addr, 0);
        rst_n = 1'b1;
        idle(2, 1'b0);

        // T1: back-to-back rows, ready always high
        $display("[TB] T1 basic tile");
        clear_logs();
        done_base = done_cnt;
        apply_stimulus(1'b1, 10'h100, 1'b0, '0, 1'b1);
        strobe_cyc = 0;
        for (int r = 0; r < RN; r++) begin
            apply_stimulus(1'b0, 10'h100, 1'b1, row_pat(r), 1'b1);
            if (r == 0) strobe_cyc = cyc;
        end
        idle(15, 1'b1);
        check_output("t1_count", log_addr.size(), RN);
        check_output("t1_addr0", addr_at(0), 64'h100);
        check_output("t1_data0", data_at(0), 64'h03020100);
        check_output("t1_addr5", addr_at(5), 64'h105);
        check_output("t1_data5", data_at(5), 64'h53525150);
        check_output("t1_latency", (log_cyc.size() > 0) ? log_cyc[0] - strobe_cyc : -1, 4);
        check_output("t1_done", done_cnt - done_base, 1);
        check_output("t1_busy_after", busy_o, 0);

        // T2: GLB stalls while the first rows arrive
        $display("[TB] T2 stalled GLB");
        clear_logs();
        done_base = done_cnt;
        apply_stimulus(1'b1, 10'h200, 1'b0, '0, 1'b0);
        for (int r = 0; r < RN; r++) apply_stimulus(1'b0, 10'h200, 1'b1, row_pat(r), 1'b0);
        check_output("t2_wren_held", glb_bus.wren, 1);
        check_output("t2_addr_held", glb_bus.addr, 10'h200);
        idle(1, 1'b0);
        check_output("t2_addr_stable", glb_bus.addr, 10'h200);
        check_output("t2_data_stable", glb_bus.wdata, row_pat(0));
        idle(15, 1'b1);
        check_output("t2_count", log_addr.size(), RN);
        ok = 1;
        for (int i = 0; i < RN; i++) begin
            if (addr_at(i) != 64'(10'h200 + i) || data_at(i) != 64'(row_pat(i))) ok = 0;
        end
        check_output("t2_order", ok, 1);
        check_output("t2_overflow", overflow_o, 0);
        check_output("t2_done", done_cnt - done_base, 1);

        // T3: fifth row hits a full FIFO with no pop
        $display("[TB] T3 overflow");
        clear_logs();
        done_base = done_cnt;
        apply_stimulus(1'b1, 10'h010, 1'b0, '0, 1'b0);
        for (int r = 0; r < 5; r++) apply_stimulus(1'b0, 10'h010, 1'b1, row_pat(r), 1'b0);
        idle(6, 1'b0);
        check_output("t3_overflow_set", overflow_o, 1);
        idle(12, 1'b1);
        check_output("t3_count", log_addr.size(), 4);
        check_output("t3_no_done", done_cnt - done_base, 0);
        check_output("t3_still_busy", busy_o, 1);
        apply_stimulus(1'b1, 10'h020, 1'b0, '0, 1'b1);
        idle(1, 1'b1);
        check_output("t3_overflow_cleared", overflow_o, 0);

        // T4: push into a full FIFO in the same cycle as a handshake
        $display("[TB] T4 full push with pop");
        clear_logs();
        done_base = done_cnt;
        apply_stimulus(1'b1, 10'h080, 1'b0, '0, 1'b0);
        for (int r = 0; r < 4; r++) apply_stimulus(1'b0, 10'h080, 1'b1, row_pat(r), 1'b0);
        idle(4, 1'b0);
        apply_stimulus(1'b0, 10'h080, 1'b1, row_pat(4), 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(3, 1'b0);
        check_output("t4_no_overflow", overflow_o, 0);
        check_output("t4_wren", glb_bus.wren, 1);
        check_output("t4_one_write", log_addr.size(), 1);
        apply_stimulus(1'b0, 10'h080, 1'b1, row_pat(5), 1'b1);
        idle(15, 1'b1);
        check_output("t4_count", log_addr.size(), RN);
        check_output("t4_data4", data_at(4), row_pat(4));
        check_output("t4_data5", data_at(5), row_pat(5));
        check_output("t4_addr5", addr_at(5), 64'h085);
        check_output("t4_overflow_end", overflow_o, 0);
        check_output("t4_done", done_cnt - done_base, 1);

        // T5: address wraps past the top of the GLB
        $display("[TB] T5 address wrap");
        clear_logs();
        apply_stimulus(1'b1, 10'h3FE, 1'b0, '0, 1'b1);
        for (int r = 0; r < RN; r++) apply_stimulus(1'b0, 10'h3FE, 1'b1, row_pat(r), 1'b1);
        idle(15, 1'b1);
        check_output("t5_addr0", addr_at(0), 64'h3FE);
        check_output("t5_addr1", addr_at(1), 64'h3FF);
        check_output("t5_addr2", addr_at(2), 64'h000);
        check_output("t5_addr3", addr_at(3), 64'h001);

        // T6: asynchronous reset in the middle of a tile
        $display("[TB] T6 reset mid-tile");
        clear_logs();
        apply_stimulus(1'b1, 10'h150, 1'b0, '0, 1'b1);
        for (int r = 0; r < 4; r++) apply_stimulus(1'b0, 10'h150, 1'b1, row_pat(r), 1'b1);
        idle(2, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        n_before = log_addr.size();
        #1;
        check_output("t6_wren", glb_bus.wren, 0);
        check_output("t6_addr", glb_bus.addr, 0);
        check_output("t6_wdata", glb_bus.wdata, 0);
        check_output("t6_busy", busy_o, 0);
        check_output("t6_done", done_o, 0);
        check_output("t6_overflow", overflow_o, 0);
        idle(2, 1'b1);
        rst_n = 1'b1;
        idle(2, 1'b1);
        check_output("t6_writes_before_reset", n_before, 2);
        check_output("t6_no_write_after", log_addr.size(), n_before);
        clear_logs();
        done_base = done_cnt;
        apply_stimulus(1'b1, 10'h150, 1'b0, '0, 1'b1);
        for (int r = 0; r < RN; r++) apply_stimulus(1'b0, 10'h150, 1'b1, row_pat(8 + r), 1'b1);
        idle(15, 1'b1);
        check_output("t6_clean_addr0", addr_at(0), 64'h150);
        check_output("t6_clean_data0", data_at(0), row_pat(8));
        check_output("t6_clean_done", done_cnt - done_base, 1);

        // randomized tiles: gaps, stalls, occasional restarts
        $display("[TB] random phase");
        for (int t = 0; t < 10; t++) begin
            apply_stimulus(1'b1, AW'($urandom), 1'b0, '0, 1'b1);
            for (int k = 0; k < 70; k++) begin
                v   = ($urandom_range(0, 9) < 7);
                rdy = ($urandom_range(0, 9) < 6);
                st  = ($urandom_range(0, 59) == 0);
                apply_stimulus(st, AW'($urandom), v, RW'($urandom), rdy);
            end
            idle(20, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
